// File: rtl/seq_divider_rnd.sv
// Sequential unsigned restoring divider with an optional round-half-up step.
// One quotient bit per clock, MSB first. A start/busy/done handshake carries
// each request. Divide-by-zero skips the iterations and returns a saturated
// quotient with the zero flag set.
module seq_divider_rnd #(
  parameter int DIVIDEND_W = 13,
  parameter int DIVISOR_W  = 5
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Start,
  input  logic                  i_Round,
  input  logic [DIVIDEND_W-1:0] i_Dividendo,
  input  logic [DIVISOR_W-1:0]  i_Divisor,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [DIVIDEND_W-1:0] o_Result,
  output logic [DIVISOR_W-1:0]  o_Residuo,
  output logic                  o_DivZero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ROUND = 2'd2
  } state_t;

  state_t state_q, state_d;

  // The dividend register doubles as the quotient register: each iteration
  // shifts one dividend bit out of the top and one quotient bit in at the bottom.
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  // The remainder is always below the divisor, so DIVISOR_W bits hold it.
  // Only the shifted value needs the extra bit.
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rnd_q, rnd_d;
  logic                  zero_q, zero_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVIDEND_W-1:0] result_q, result_d;
  logic [DIVISOR_W-1:0]  residuo_q, residuo_d;
  logic                  divzero_q, divzero_d;

  logic [DIVISOR_W:0]    rem_shift_s;
  logic                  sub_ok_s;
  logic                  round_up_s;
  logic [DIVIDEND_W-1:0] quot_inc_s;

  // Per-iteration restoring step, plus the rounding decision and saturating increment.
  always_comb begin
    rem_shift_s = {rem_q, dvd_q[DIVIDEND_W-1]};
    sub_ok_s    = (rem_shift_s >= {1'b0, dvs_q});
    round_up_s  = rnd_q && ({rem_q, 1'b0} >= {1'b0, dvs_q});
    if (&dvd_q) begin
      quot_inc_s = dvd_q;
    end else begin
      quot_inc_s = dvd_q + DIVIDEND_W'(1);
    end
  end

  // FSM next-state and datapath/output next values.
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    rnd_d     = rnd_q;
    zero_d    = zero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    residuo_d = residuo_q;
    divzero_d = divzero_q;

    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          dvd_d  = i_Dividendo;
          dvs_d  = i_Divisor;
          rnd_d  = i_Round;
          rem_d  = {DIVISOR_W{1'b0}};
          busy_d = 1'b1;
          if (i_Divisor == {DIVISOR_W{1'b0}}) begin
            zero_d  = 1'b1;
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_ROUND;
          end else begin
            zero_d  = 1'b0;
            cnt_d   = CNT_W'(DIVIDEND_W);
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        if (sub_ok_s) begin
          rem_d = DIVISOR_W'(rem_shift_s - {1'b0, dvs_q});
        end else begin
          rem_d = rem_shift_s[DIVISOR_W-1:0];
        end
        dvd_d = {dvd_q[DIVIDEND_W-2:0], sub_ok_s};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_ROUND;
        end else begin
          state_d = ST_CALC;
        end
      end

      ST_ROUND: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (zero_q) begin
          result_d  = {DIVIDEND_W{1'b1}};
          residuo_d = {DIVISOR_W{1'b0}};
          divzero_d = 1'b1;
        end else begin
          if (round_up_s) begin
            result_d = quot_inc_s;
          end else begin
            result_d = dvd_q;
          end
          residuo_d = rem_q;
          divzero_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, operand and output registers with asynchronous clear.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      dvd_q     <= {DIVIDEND_W{1'b0}};
      dvs_q     <= {DIVISOR_W{1'b0}};
      rem_q     <= {DIVISOR_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      rnd_q     <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= {DIVIDEND_W{1'b0}};
      residuo_q <= {DIVISOR_W{1'b0}};
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      rnd_q     <= rnd_d;
      zero_q    <= zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      residuo_q <= residuo_d;
      divzero_q <= divzero_d;
    end
  end

  assign o_Busy    = busy_q;
  assign o_Done    = done_q;
  assign o_Result  = result_q;
  assign o_Residuo = residuo_q;
  assign o_DivZero = divzero_q;

endmodule
